tri_bus_arbiter: RTL and testbench
==================================

Name: tri_bus_arbiter

Overview:
- Round-robin arbiter that generates the per-driver enables for a shared tri-state bus.
- Each oEna bit drives the enable input of one tri-state gate; the data inputs of those gates come from the requesters.
- Guarantees at most one enable is high at any time.
- Inserts turnaround cycles with all enables low (bus at Z) between owners, so two drivers never fight on a handover.

Parameters:
- N, 4, number of requesters/tri-state drivers (2..16).
- W, 2, owner index width; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive cycles one owner may keep the bus (>=1).
- TURN_CYC, 1, bus-float cycles inserted after every release (>=1).

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iReq  input  N  request vector; bit i high = requester i wants the bus.
- oEna  output  N  one-hot-or-zero enable vector to the tri-state gates.
- oOwner  output  W  index of the current owner; valid only while oBusy=1.
- oBusy  output  1  high while some oEna bit is high.
- oTurn  output  1  high during turnaround cycles.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (iClk, iRst).
- All outputs are registered.
- Reset values (iRst sampled high at an edge): oEna=0, oOwner=0, oBusy=0, oTurn=0, state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- Reset mid-ownership drops oEna to 0 at that same edge; no turnaround is applied.
- States: IDLE, OWN, TURN.
- IDLE, iReq==0: stay in IDLE; outputs stay 0.
- IDLE, iReq!=0: grant the first set bit scanning from ptr upward, wrapping modulo N.
  - Same edge: state=OWN, oEna=one-hot(g), oOwner=g, oBusy=1, cnt=1.
  - Latency: request sampled at edge k -> enable visible after edge k (one cycle from request assertion).
- OWN, leave when iReq[oOwner]==0 OR cnt==MAX_HOLD. At that edge:
  - oEna=0, oBusy=0, oTurn=1.
  - ptr=(oOwner+1) mod N.
  - cnt reset for the turnaround count; state=TURN.
- OWN, otherwise: stay in OWN; cnt=cnt+1.
- Requests from other bits are ignored during OWN.
- TURN: held for exactly TURN_CYC cycles with oEna=0 and oTurn=1.
  - On the last TURN cycle's edge: oTurn=0, state=IDLE.
  - Arbitration happens in the following IDLE cycle, so the minimum gap between two owners is TURN_CYC+1 idle-bus cycles.
- A requester hitting MAX_HOLD with iReq still high re-competes as normal.
  - Because ptr has advanced, it wins again only if no other bit is set.
- Invariants, checked every cycle:
  - popcount(oEna)<=1.
  - oBusy==|oEna.
  - oTurn and oBusy are never both 1.
  - oEna never goes directly from one one-hot value to a different one.
- Request deasserted during TURN or IDLE before sampling: that requester is simply not granted; no latching.
- ptr wraps from N-1 to 0.
- cnt width is ceil(log2(MAX_HOLD+1)); it never overflows.

Test Plan:
All scenarios use N=4, MAX_HOLD=4, TURN_CYC=1.
1. Reset: iRst=1 for 2 edges with iReq=4'b1111 -> oEna=0, oBusy=0, oTurn=0; first edge after iRst=0 -> oEna=4'b0001, oOwner=0.
2. Single short request: iReq=4'b0100 for 2 cycles then 0 -> oEna=0100 for 2 cycles, then 1 cycle oTurn=1 with oEna=0, then IDLE with everything 0.
3. Round-robin: iReq=4'b1111 held -> grants 0,1,2,3,0.
   - Each owner holds 4 cycles.
   - Each tenure is followed by 1 TURN cycle and 1 IDLE cycle with oEna=0.
4. MAX_HOLD with a sole requester: iReq=4'b1000 held 12 cycles -> oEna=1000 for 4 cycles, then 2 cycles at 0, repeated; never more than 4 consecutive.
5. Wrap and skip: ptr=3 after owner 2 releases, iReq=4'b0011 -> next grant is owner 0, then owner 1.
6. Reset mid-ownership: during OWN with oEna=0010, pulse iRst for 1 edge -> oEna=0 at that edge, ptr=0; with iReq=0010 still high, the next edge grants owner 1 again.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tri_bus_arbiter
// Description : Round-robin enable generator for a shared tri-state bus with
//               turnaround (bus-float) cycles inserted between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 2,
   parameter int MAX_HOLD = 8,
   parameter int TURN_CYC = 1
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic [N-1:0] iReq,
   output logic [N-1:0] oEna,
   output logic [W-1:0] oOwner,
   output logic         oBusy,
   output logic         oTurn
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam int TW = $clog2(TURN_CYC + 1);

   localparam logic [CW-1:0] c_max_hold = CW'(MAX_HOLD);
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);
   localparam logic [TW-1:0] c_turn_cyc = TW'(TURN_CYC);
   localparam logic [TW-1:0] c_tcnt_one = TW'(1);
   localparam logic [W-1:0]  c_last     = W'(N - 1);
   localparam logic [W:0]    c_n_ext    = (W + 1)'(N);
   localparam logic [N-1:0]  c_one      = N'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [N-1:0]  ena_q, ena_d;
   logic [W-1:0]  owner_q, owner_d;
   logic          busy_q, busy_d;
   logic          turn_q, turn_d;

   logic          gnt_vld;
   logic [W-1:0]  gnt_idx;
   logic [W:0]    scan_sum;
   logic [W-1:0]  scan_sel;

   // First requester at or above ptr, wrapping modulo N.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_sum = '0;
      scan_sel = '0;
      for (int i = 0; i < N; i++) begin
         scan_sum = {1'b0, ptr_q} + (W + 1)'(i);
         if (scan_sum >= c_n_ext) begin
            scan_sum = scan_sum - c_n_ext;
         end
         scan_sel = scan_sum[W-1:0];
         if (!gnt_vld && iReq[scan_sel]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan_sel;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      ena_d   = ena_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      turn_d  = turn_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d = OWN;
               ena_d   = c_one << gnt_idx;
               owner_d = gnt_idx;
               busy_d  = 1'b1;
               cnt_d   = c_cnt_one;
            end
         end
         OWN: begin
            if (!iReq[owner_q] || (cnt_q == c_max_hold)) begin
               state_d = TURN;
               ena_d   = '0;
               busy_d  = 1'b0;
               turn_d  = 1'b1;
               ptr_d   = (owner_q == c_last) ? '0 : owner_q + 1'b1;
               cnt_d   = '0;
               tcnt_d  = c_tcnt_one;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TURN: begin
            // tcnt_q counts the float cycle currently being shown on the bus.
            if (tcnt_q == c_turn_cyc) begin
               state_d = IDLE;
               turn_d  = 1'b0;
               tcnt_d  = '0;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ena_d   = '0;
            busy_d  = 1'b0;
            turn_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         ena_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         turn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         ena_q   <= ena_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         turn_q  <= turn_d;
      end
   end

   assign oEna   = ena_q;
   assign oOwner = owner_q;
   assign oBusy  = busy_q;
   assign oTurn  = turn_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_bus_arbiter
// Description : Scenario tasks plus randomized run against a bus-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_bus_arbiter;

   localparam int N        = 4;
   localparam int W        = 2;
   localparam int MAX_HOLD = 4;
   localparam int TURN_CYC = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] ena;
   logic [W-1:0] owner;
   logic         busy;
   logic         turn;

   int checks = 0;
   int errors = 0;

   // Model: who holds the bus (-1 = nobody), how long, float cycles left.
   int m_owner  = -1;
   int m_last   = 0;
   int m_tenure = 0;
   int m_float  = 0;
   int m_ptr    = 0;

   always #5 clk = ~clk;

   tri_bus_arbiter #(
      .N        (N),
      .W        (W),
      .MAX_HOLD (MAX_HOLD),
      .TURN_CYC (TURN_CYC)
   ) dut (
      .iClk   (clk),
      .iRst   (rst),
      .iReq   (req),
      .oEna   (ena),
      .oOwner (owner),
      .oBusy  (busy),
      .oTurn  (turn)
   );

   task automatic model_step(input logic r, input logic [N-1:0] q);
      bit found;
      int c;
      if (r) begin
         m_owner = -1; m_last = 0; m_tenure = 0; m_float = 0; m_ptr = 0;
      end else if (m_owner >= 0) begin
         if (!q[m_owner] || m_tenure == MAX_HOLD) begin
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_float  = TURN_CYC;
            m_tenure = 0;
         end else begin
            m_tenure++;
         end
      end else if (m_float > 0) begin
         m_float--;
      end else if (q != '0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && q[c]) begin
               found = 1'b1;
               m_owner = c; m_last = c; m_tenure = 1;
            end
         end
      end
   endtask

   function automatic logic [N-1:0] onehot(input int o);
      logic [N-1:0] v;
      v = '0;
      if (o >= 0) v[o] = 1'b1;
      return v;
   endfunction

   // Advances one clock; DUT outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      model_step(rst, req);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111;
      tick(); tick();
      checks++;
      if (ena !== 4'b0000) begin
         errors++; $display("FAIL reset_ena got=%b want=0000", ena);
      end
      checks++;
      if (busy !== 1'b0 || turn !== 1'b0 || owner !== 2'd0) begin
         errors++; $display("FAIL reset_flags got busy=%b turn=%b owner=%0d want 0/0/0", busy, turn, owner);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ena !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant got ena=%b owner=%0d busy=%b want 0001/0/1", ena, owner, busy);
      end
   endtask

   task automatic test_single_request();
      logic [N-1:0] exp_e [4];
      logic         exp_t [4];
      exp_e = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
      exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
      rst = 1'b1; req = '0; tick();
      rst = 1'b0; req = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) req = '0;
         tick();
         checks++;
         if (ena !== exp_e[i] || turn !== exp_t[i] || busy !== (exp_e[i] != '0)) begin
            errors++;
            $display("FAIL single_req step=%0d got ena=%b turn=%b busy=%b want ena=%b turn=%b",
                     i, ena, turn, busy, exp_e[i], exp_t[i]);
         end
      end
   endtask

   // All four requesting: 4 owned cycles, 1 turn, 1 idle, repeating 0,1,2,3,0.
   task automatic test_round_robin();
      int p, g;
      logic [N-1:0] e;
      rst = 1'b1; req = '0; tick();
      rst = 1'b0; req = 4'b1111;
      for (int t = 0; t < 30; t++) begin
         tick();
         p = t % 6;
         g = (t / 6) % N;
         e = (p < 4) ? onehot(g) : '0;
         checks++;
         if (ena !== e || turn !== (p == 4) || (p < 4 && owner !== 2'(g))) begin
            errors++;
            $display("FAIL round_robin cyc=%0d got ena=%b turn=%b owner=%0d want ena=%b turn=%b owner=%0d",
                     t, ena, turn, owner, e, (p == 4), g);
         end
      end
   endtask

   task automatic test_max_hold();
      int run;
      logic [N-1:0] e;
      rst = 1'b1; req = '0; tick();
      rst = 1'b0; req = 4'b1000;
      run = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         e = ((t % 6) < 4) ? 4'b1000 : 4'b0000;
         run = (ena != '0) ? run + 1 : 0;
         checks++;
         if (ena !== e || run > MAX_HOLD) begin
            errors++;
            $display("FAIL max_hold cyc=%0d got ena=%b run=%0d want ena=%b run<=%0d",
                     t, ena, run, e, MAX_HOLD);
         end
      end
   endtask

   task automatic test_wrap_skip();
      logic [N-1:0] e;
      rst = 1'b1; req = '0; tick();
      rst = 1'b0; req = 4'b0100; tick();
      req = '0; tick(); tick();
      req = 4'b0011;
      for (int t = 0; t < 7; t++) begin
         tick();
         e = (t < 4) ? 4'b0001 : (t == 6) ? 4'b0010 : 4'b0000;
         checks++;
         if (ena !== e) begin
            errors++; $display("FAIL wrap_skip cyc=%0d got ena=%b want ena=%b", t, ena, e);
         end
      end
   endtask

   task automatic test_reset_mid_own();
      rst = 1'b1; req = '0; tick();
      rst = 1'b0; req = 4'b0010; tick();
      req = '0; tick(); tick();
      req = 4'b0010; tick();
      checks++;
      if (ena !== 4'b0010) begin
         errors++; $display("FAIL reset_mid_setup got ena=%b want 0010", ena);
      end
      rst = 1'b1; tick();
      checks++;
      if (ena !== 4'b0000 || turn !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_drop got ena=%b turn=%b busy=%b want 0000/0/0", ena, turn, busy);
      end
      // Owner 1 must win over owner 2 only if the pointer was cleared.
      rst = 1'b0; req = 4'b0110; tick();
      checks++;
      if (ena !== 4'b0010 || owner !== 2'd1) begin
         errors++; $display("FAIL reset_mid_regrant got ena=%b owner=%0d want 0010/1", ena, owner);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] prev;
      logic [N-1:0] e;
      rst = 1'b1; req = '0; tick();
      rst = 1'b0;
      prev = ena;
      for (int t = 0; t < 600; t++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
         end
         rst = ($urandom_range(0, 79) == 0);
         tick();
         e = onehot(m_owner);
         checks++;
         if (ena !== e || busy !== (m_owner >= 0) || turn !== (m_float > 0)
             || (m_owner >= 0 && owner !== 2'(m_last))) begin
            errors++;
            $display("FAIL random_model cyc=%0d got ena=%b busy=%b turn=%b owner=%0d want ena=%b busy=%b turn=%b owner=%0d",
                     t, ena, busy, turn, owner, e, (m_owner >= 0), (m_float > 0), m_last);
         end
         checks++;
         if ($countones(ena) > 1 || busy !== (|ena) || (turn && busy)) begin
            errors++;
            $display("FAIL random_invariant cyc=%0d got ena=%b busy=%b turn=%b want onehot0, busy=|ena, not turn&busy",
                     t, ena, busy, turn);
         end
         checks++;
         if (prev != '0 && ena != '0 && ena != prev) begin
            errors++;
            $display("FAIL random_handover cyc=%0d got ena %b -> %b want a zero cycle between owners", t, prev, ena);
         end
         prev = ena;
      end
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      test_reset();
      test_single_request();
      test_round_robin();
      test_max_hold();
      test_wrap_skip();
      test_reset_mid_own();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
